// File: rtl/seq_divider_bus.sv
// Restoring divider (unsigned or two's-complement) with a BUS_W-bit valid/ready
// front end that collects both operands and a back end that streams quotient then remainder.
module seq_divider_bus #(
  parameter int DATA_W = 16,
  parameter int BUS_W  = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [BUS_W-1:0] in_data,
  input  logic             in_signed,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [BUS_W-1:0] out_data,
  output logic             out_last,
  output logic             out_error,
  output logic             busy
);

  localparam int N      = DATA_W / BUS_W;
  localparam int BEATS  = 2 * N;
  localparam int CNT_W  = (BEATS > 2) ? $clog2(BEATS) : 1;
  localparam int DIV_CW = $clog2(DATA_W + 1);
  localparam logic [DATA_W-1:0] MIN_NEG = {1'b1, {(DATA_W-1){1'b0}}};

  generate
    if ((DATA_W % BUS_W) != 0 || DATA_W < BUS_W || DATA_W < 2) begin : g_bad_width
      $error("seq_divider_bus: DATA_W must be a non-zero multiple of BUS_W");
    end
  endgenerate

  typedef enum logic [2:0] {RECV, PREP, DIV, FIX, SEND} state_t;

  state_t state, state_nxt;

  logic [2*DATA_W-1:0] in_sr;
  logic [2*DATA_W-1:0] out_sr;
  logic [CNT_W-1:0]    in_cnt;
  logic [CNT_W-1:0]    out_cnt;
  logic [DIV_CW-1:0]   div_cnt;
  logic                is_signed;
  logic [DATA_W-1:0]   quo;
  logic [DATA_W:0]     rem;
  logic [DATA_W-1:0]   dvs_mag;
  logic                q_neg;
  logic                r_neg;
  logic                div_zero;
  logic                ovf;
  logic                err;

  logic [DATA_W-1:0]   dividend;
  logic [DATA_W-1:0]   divisor;
  logic                dvd_neg;
  logic                dvs_neg;
  logic [DATA_W-1:0]   dvd_mag_c;
  logic [DATA_W-1:0]   dvs_mag_c;
  logic [DATA_W+1:0]   rem_sh;
  logic [DATA_W+1:0]   trial;
  logic [DATA_W-1:0]   q_fix;
  logic [DATA_W-1:0]   r_fix;
  logic                last_in;
  logic                last_out;
  logic                div_done;

  // Beats shift in from the top, so after 2N beats the dividend's LS beat sits at bit 0.
  assign dividend  = in_sr[DATA_W-1:0];
  assign divisor   = in_sr[2*DATA_W-1:DATA_W];
  assign dvd_neg   = is_signed & dividend[DATA_W-1];
  assign dvs_neg   = is_signed & divisor[DATA_W-1];
  assign dvd_mag_c = dvd_neg ? -dividend : dividend;
  assign dvs_mag_c = dvs_neg ? -divisor : divisor;

  assign rem_sh    = {rem, quo[DATA_W-1]};
  assign trial     = rem_sh - {2'b00, dvs_mag};

  assign last_in   = (in_cnt == CNT_W'(BEATS - 1));
  assign last_out  = (out_cnt == CNT_W'(BEATS - 1));
  assign div_done  = (div_cnt == DIV_CW'(DATA_W - 1));

  always_comb begin
    q_fix = quo;
    r_fix = rem[DATA_W-1:0];
    if (div_zero) begin
      q_fix = '1;
      r_fix = dividend;
    end else if (ovf) begin
      q_fix = MIN_NEG;
      r_fix = '0;
    end else begin
      if (q_neg) q_fix = -quo;
      if (r_neg) r_fix = -rem[DATA_W-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state <= RECV;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      RECV: begin
        in_ready = 1'b1;
        if (in_valid && last_in) state_nxt = PREP;
      end
      PREP: state_nxt = DIV;
      DIV:  if (div_done) state_nxt = FIX;
      FIX:  state_nxt = SEND;
      SEND: begin
        out_valid = 1'b1;
        if (out_ready && last_out) state_nxt = RECV;
      end
      default: state_nxt = RECV;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      in_sr     <= '0;
      out_sr    <= '0;
      in_cnt    <= '0;
      out_cnt   <= '0;
      div_cnt   <= '0;
      is_signed <= 1'b0;
      quo       <= '0;
      rem       <= '0;
      dvs_mag   <= '0;
      q_neg     <= 1'b0;
      r_neg     <= 1'b0;
      div_zero  <= 1'b0;
      ovf       <= 1'b0;
      err       <= 1'b0;
    end else begin
      case (state)
        RECV: begin
          if (in_valid) begin
            in_sr  <= {in_data, in_sr[2*DATA_W-1:BUS_W]};
            in_cnt <= last_in ? '0 : in_cnt + 1'b1;
            if (in_cnt == '0) is_signed <= in_signed;
          end
        end
        PREP: begin
          quo      <= dvd_mag_c;
          dvs_mag  <= dvs_mag_c;
          rem      <= '0;
          q_neg    <= dvd_neg ^ dvs_neg;
          r_neg    <= dvd_neg;
          div_zero <= (divisor == '0);
          ovf      <= is_signed && (dividend == MIN_NEG) && (divisor == '1);
          div_cnt  <= '0;
        end
        DIV: begin
          // Non-negative trial means the shifted remainder covers the divisor.
          if (!trial[DATA_W+1]) rem <= trial[DATA_W:0];
          else                  rem <= rem_sh[DATA_W:0];
          quo     <= {quo[DATA_W-2:0], ~trial[DATA_W+1]};
          div_cnt <= div_cnt + 1'b1;
        end
        FIX: begin
          out_sr  <= {r_fix, q_fix};
          out_cnt <= '0;
          err     <= div_zero;
        end
        SEND: begin
          if (out_ready) begin
            out_sr  <= {{BUS_W{1'b0}}, out_sr[2*DATA_W-1:BUS_W]};
            out_cnt <= last_out ? '0 : out_cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign out_data  = (state == SEND) ? out_sr[BUS_W-1:0] : '0;
  assign out_last  = (state == SEND) && last_out;
  assign out_error = (state == SEND) && err;
  assign busy      = (state != RECV) || (in_cnt != '0);

endmodule

// File: tb/tb_seq_divider_bus.sv
// Bench for seq_divider_bus: a 16-bit and a 32-bit instance driven through a shared
// transaction task, checked against an arithmetic reference model.
module tb_seq_divider_bus;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [1:0]      in_valid, in_ready, in_signed, out_valid, out_ready, out_last, out_error, busy;
  logic [1:0][7:0] in_data, out_data;
  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  seq_divider_bus #(.DATA_W(16), .BUS_W(8)) dut16 (
    .clk(clk), .rst(rst), .in_valid(in_valid[0]), .in_ready(in_ready[0]), .in_data(in_data[0]),
    .in_signed(in_signed[0]), .out_valid(out_valid[0]), .out_ready(out_ready[0]),
    .out_data(out_data[0]), .out_last(out_last[0]), .out_error(out_error[0]), .busy(busy[0]));

  seq_divider_bus #(.DATA_W(32), .BUS_W(8)) dut32 (
    .clk(clk), .rst(rst), .in_valid(in_valid[1]), .in_ready(in_ready[1]), .in_data(in_data[1]),
    .in_signed(in_signed[1]), .out_valid(out_valid[1]), .out_ready(out_ready[1]),
    .out_data(out_data[1]), .out_last(out_last[1]), .out_error(out_error[1]), .busy(busy[1]));

  function automatic void model(input int w, input logic [31:0] a_in, input logic [31:0] b_in,
                                input bit sgn, output logic [31:0] q, output logic [31:0] r,
                                output bit err);
    logic [31:0] mask, a, b;
    longint sa, sb, mn, qs, rs;
    mask = (w == 32) ? 32'hFFFF_FFFF : 32'h0000_FFFF;
    a = a_in & mask;
    b = b_in & mask;
    err = 1'b0;
    if (b == 0) begin
      q = mask; r = a; err = 1'b1;
    end else if (!sgn) begin
      q = a / b; r = a % b;
    end else begin
      sa = a[w-1] ? longint'(a) - (longint'(1) << w) : longint'(a);
      sb = b[w-1] ? longint'(b) - (longint'(1) << w) : longint'(b);
      mn = -(longint'(1) << (w - 1));
      if (sa == mn && sb == -1) begin
        q = a; r = '0;
      end else begin
        qs = sa / sb;
        rs = sa % sb;
        q = 32'(qs) & mask;
        r = 32'(rs) & mask;
      end
    end
  endfunction

  // rmode: 0 = always ready, 1 = fixed stall pattern, 2 = random stalls and input gaps.
  // pbad counts handshake/stability/framing problems seen during the transaction.
  task automatic run_op(input int k, input logic [31:0] a, input logic [31:0] b, input bit sgn,
                        input int rmode, input bit hold_valid,
                        output logic [31:0] q, output logic [31:0] r, output bit err,
                        output int lat, output int pbad);
    int w, nb, t, got, cyc;
    bit rdy, held;
    logic [7:0] beat, pd;
    logic pl, pe;
    logic [6:0] pat;
    pat = 7'b1101001;
    w = (k == 1) ? 32 : 16;
    nb = w / 8;
    q = '0; r = '0; err = 1'b0; lat = 0; pbad = 0;
    held = 1'b0; pd = '0; pl = 1'b0; pe = 1'b0;
    for (int i = 0; i < 2 * nb; i++) begin
      beat = (i < nb) ? a[8*i +: 8] : b[8*(i-nb) +: 8];
      @(negedge clk);
      if (rmode == 2 && $urandom_range(0, 3) == 0) begin
        in_valid[k] = 1'b0;
        @(negedge clk);
      end
      in_valid[k] = 1'b1;
      in_data[k] = beat;
      in_signed[k] = (i == 0) ? sgn : ~sgn;
      t = 0;
      while (!in_ready[k] && t < 100) begin
        @(negedge clk);
        t++;
      end
      if (t >= 100) pbad++;
      @(posedge clk);
    end
    @(negedge clk);
    in_data[k] = 8'hA5;
    in_valid[k] = hold_valid;
    while (!out_valid[k] && lat < 200) begin
      if (in_ready[k] || !busy[k]) pbad++;
      @(negedge clk);
      lat++;
    end
    got = 0; cyc = 0;
    while (got < 2 * nb && cyc < 500) begin
      if (in_ready[k] || !busy[k] || !out_valid[k]) pbad++;
      if (held && (out_data[k] !== pd || out_last[k] !== pl || out_error[k] !== pe)) pbad++;
      rdy = (rmode == 0) ? 1'b1 : (rmode == 1) ? pat[cyc % 7] : 1'($urandom_range(0, 1));
      out_ready[k] = rdy;
      if (rdy) begin
        if (got < nb) q[8*got +: 8] = out_data[k];
        else          r[8*(got-nb) +: 8] = out_data[k];
        if (out_last[k] !== (got == 2 * nb - 1)) pbad++;
        if (got == 0) err = out_error[k];
        else if (out_error[k] !== err) pbad++;
        got++;
        held = 1'b0;
      end else begin
        held = 1'b1;
        pd = out_data[k]; pl = out_last[k]; pe = out_error[k];
      end
      @(negedge clk);
      cyc++;
    end
    out_ready[k] = 1'b0;
    in_valid[k] = 1'b0;
    if (got < 2 * nb || !in_ready[k] || busy[k] || out_valid[k]) pbad++;
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      total++; if (in_ready[k] !== 1'b1) begin bad++; $display("FAIL rst_in_ready[%0d] got=%b exp=1", k, in_ready[k]); end
      total++; if (out_valid[k] !== 1'b0) begin bad++; $display("FAIL rst_out_valid[%0d] got=%b exp=0", k, out_valid[k]); end
      total++; if (out_data[k] !== 8'h00) begin bad++; $display("FAIL rst_out_data[%0d] got=%h exp=00", k, out_data[k]); end
      total++; if ({out_last[k], out_error[k], busy[k]} !== 3'b000) begin bad++; $display("FAIL rst_flags[%0d] got=%b exp=000", k, {out_last[k], out_error[k], busy[k]}); end
    end
    rst = 1'b0;
  endtask

  task automatic test_unsigned();
    logic [31:0] q, r; bit err; int lat, pb;
    run_op(0, 32'd1000, 32'd7, 1'b0, 0, 1'b0, q, r, err, lat, pb);
    total++; if (q !== 32'h008E) begin bad++; $display("FAIL u1000_7_q got=%h exp=008e", q); end
    total++; if (r !== 32'h0006) begin bad++; $display("FAIL u1000_7_r got=%h exp=0006", r); end
    total++; if (err !== 1'b0) begin bad++; $display("FAIL u1000_7_err got=%b exp=0", err); end
    total++; if (lat !== 18) begin bad++; $display("FAIL u1000_7_latency got=%0d exp=18", lat); end
    total++; if (pb !== 0) begin bad++; $display("FAIL u1000_7_protocol got=%0d exp=0", pb); end
  endtask

  task automatic test_signed();
    logic [31:0] q, r; bit err; int lat, pb;
    run_op(0, 32'hFFF9, 32'h0002, 1'b1, 0, 1'b0, q, r, err, lat, pb);
    total++; if ({q, r} !== {32'hFFFD, 32'hFFFF}) begin bad++; $display("FAIL s_m7_2 got=%h/%h exp=fffd/ffff", q, r); end
    total++; if (err !== 1'b0 || pb !== 0) begin bad++; $display("FAIL s_m7_2_flags got=err%b,p%0d exp=err0,p0", err, pb); end
    run_op(0, 32'h0007, 32'hFFFE, 1'b1, 0, 1'b0, q, r, err, lat, pb);
    total++; if ({q, r} !== {32'hFFFD, 32'h0001}) begin bad++; $display("FAIL s_7_m2 got=%h/%h exp=fffd/0001", q, r); end
  endtask

  task automatic test_div_zero();
    logic [31:0] q, r; bit err; int lat, pb;
    for (int s = 0; s < 2; s++) begin
      run_op(0, 32'h1234, 32'h0000, s[0], 0, 1'b0, q, r, err, lat, pb);
      total++; if ({q, r} !== {32'hFFFF, 32'h1234}) begin bad++; $display("FAIL dz_result[s%0d] got=%h/%h exp=ffff/1234", s, q, r); end
      total++; if (err !== 1'b1) begin bad++; $display("FAIL dz_err[s%0d] got=%b exp=1", s, err); end
      total++; if (lat !== 18) begin bad++; $display("FAIL dz_latency[s%0d] got=%0d exp=18", s, lat); end
      total++; if (pb !== 0) begin bad++; $display("FAIL dz_protocol[s%0d] got=%0d exp=0", s, pb); end
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] q, r; bit err; int lat, pb;
    run_op(0, 32'd1000, 32'd7, 1'b0, 1, 1'b1, q, r, err, lat, pb);
    total++; if ({q, r} !== {32'h008E, 32'h0006}) begin bad++; $display("FAIL bp_result got=%h/%h exp=008e/0006", q, r); end
    total++; if (pb !== 0) begin bad++; $display("FAIL bp_protocol got=%0d exp=0", pb); end
  endtask

  task automatic test_overflow();
    logic [31:0] q, r; bit err; int lat, pb;
    run_op(0, 32'h8000, 32'hFFFF, 1'b1, 0, 1'b0, q, r, err, lat, pb);
    total++; if ({q, r, err} !== {32'h8000, 32'h0000, 1'b0}) begin bad++; $display("FAIL ovf got=%h/%h/%b exp=8000/0000/0", q, r, err); end
    run_op(0, 32'hFFFF, 32'h0001, 1'b0, 0, 1'b0, q, r, err, lat, pb);
    total++; if ({q, r, err} !== {32'hFFFF, 32'h0000, 1'b0}) begin bad++; $display("FAIL u_max_1 got=%h/%h/%b exp=ffff/0000/0", q, r, err); end
  endtask

  task automatic test_reset_mid();
    logic [31:0] q, r; bit err; int lat, pb;
    logic [7:0] beats [4];
    beats = '{8'hE8, 8'h03, 8'h07, 8'h00};
    @(negedge clk);
    in_valid[0] = 1'b1; in_data[0] = beats[0]; in_signed[0] = 1'b0;
    @(posedge clk); @(negedge clk);
    total++; if (busy[0] !== 1'b1) begin bad++; $display("FAIL busy_first_beat got=%b exp=1", busy[0]); end
    in_valid[0] = 1'b0; rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    total++; if ({in_ready[0], busy[0]} !== 2'b10) begin bad++; $display("FAIL rst_mid_recv got=%b exp=10", {in_ready[0], busy[0]}); end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      in_valid[0] = 1'b1; in_data[0] = beats[i];
      @(posedge clk);
    end
    @(negedge clk);
    in_valid[0] = 1'b0;
    repeat (6) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    total++;
    if ({in_ready[0], out_valid[0], out_data[0], out_last[0], out_error[0], busy[0]} !== 13'b1_0_00000000_0_0_0) begin
      bad++; $display("FAIL rst_mid_div got=%b exp=1000000000000", {in_ready[0], out_valid[0], out_data[0], out_last[0], out_error[0], busy[0]});
    end
    run_op(0, 32'd1000, 32'd7, 1'b0, 0, 1'b0, q, r, err, lat, pb);
    total++; if ({q, r, err} !== {32'h008E, 32'h0006, 1'b0}) begin bad++; $display("FAIL after_rst got=%h/%h/%b exp=008e/0006/0", q, r, err); end
    total++; if (lat !== 18 || pb !== 0) begin bad++; $display("FAIL after_rst_timing got=lat%0d,p%0d exp=lat18,p0", lat, pb); end
  endtask

  task automatic test_wide();
    logic [31:0] q, r; bit err; int lat, pb;
    run_op(1, 32'd1000, 32'd7, 1'b0, 0, 1'b0, q, r, err, lat, pb);
    total++; if ({q, r, err} !== {32'd142, 32'd6, 1'b0}) begin bad++; $display("FAIL w_u1000_7 got=%h/%h/%b exp=0000008e/00000006/0", q, r, err); end
    total++; if (lat !== 34) begin bad++; $display("FAIL w_latency got=%0d exp=34", lat); end
    run_op(1, 32'hFFFF_FFF9, 32'd2, 1'b1, 0, 1'b0, q, r, err, lat, pb);
    total++; if ({q, r} !== {32'hFFFF_FFFD, 32'hFFFF_FFFF}) begin bad++; $display("FAIL w_s_m7_2 got=%h/%h exp=fffffffd/ffffffff", q, r); end
    run_op(1, 32'h1234_5678, 32'd0, 1'b1, 0, 1'b0, q, r, err, lat, pb);
    total++; if ({q, r, err} !== {32'hFFFF_FFFF, 32'h1234_5678, 1'b1}) begin bad++; $display("FAIL w_dz got=%h/%h/%b exp=ffffffff/12345678/1", q, r, err); end
    total++; if (lat !== 34 || pb !== 0) begin bad++; $display("FAIL w_dz_timing got=lat%0d,p%0d exp=lat34,p0", lat, pb); end
  endtask

  task automatic test_random();
    logic [31:0] a, b, q, r, eq, er; bit err, eerr, sgn; int lat, pb, k, w;
    for (int n = 0; n < 40; n++) begin
      k = $urandom_range(0, 1);
      w = (k == 1) ? 32 : 16;
      a = $urandom;
      case ($urandom_range(0, 3))
        0: b = '0;
        1: b = $urandom_range(0, 1) ? 32'($urandom_range(1, 15)) : -32'($urandom_range(1, 15));
        default: b = $urandom;
      endcase
      sgn = 1'($urandom_range(0, 1));
      model(w, a, b, sgn, eq, er, eerr);
      run_op(k, a, b, sgn, 2, 1'($urandom_range(0, 1)), q, r, err, lat, pb);
      total++;
      if ({q, r, err} !== {eq, er, eerr}) begin
        bad++; $display("FAIL rand[%0d] w%0d s%0d %h/%h got=%h/%h/%b exp=%h/%h/%b", n, w, sgn, a, b, q, r, err, eq, er, eerr);
      end
      total++;
      if (lat !== w + 2 || pb !== 0) begin
        bad++; $display("FAIL rand_timing[%0d] got=lat%0d,p%0d exp=lat%0d,p0", n, lat, pb, w + 2);
      end
    end
  endtask

  initial begin
    in_valid = '0; in_signed = '0; out_ready = '0; in_data = '0;
    test_reset();
    test_unsigned();
    test_signed();
    test_div_zero();
    test_backpressure();
    test_overflow();
    test_reset_mid();
    test_wide();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
